// File: rtl/rv_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: opcodes,
// decoder instruction types, FSM states and datapath select codes.
package rv_ctrl_fsm_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_ST     = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_ECSR   = 7'b1110011;

  localparam logic [2:0] INSTR_R   = 3'd0;
  localparam logic [2:0] INSTR_I   = 3'd1;
  localparam logic [2:0] INSTR_S   = 3'd2;
  localparam logic [2:0] INSTR_B   = 3'd3;
  localparam logic [2:0] INSTR_U   = 3'd4;
  localparam logic [2:0] INSTR_J   = 3'd5;
  localparam logic [2:0] INSTR_ERR = 3'd7;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT
  } ctrl_state_e;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_ALU   = 2'd1;
  localparam logic [1:0] PC_SEL_TRAP  = 2'd2;

  localparam logic [1:0] WB_SEL_ALU   = 2'd0;
  localparam logic [1:0] WB_SEL_MDR   = 2'd1;
  localparam logic [1:0] WB_SEL_PC4   = 2'd2;

  localparam logic [1:0] ALU_A_RS1    = 2'd0;
  localparam logic [1:0] ALU_A_PC     = 2'd1;
  localparam logic [1:0] ALU_A_ZERO   = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_ECALL   = 2'd1;
  localparam logic [1:0] CAUSE_BUS     = 2'd2;

endpackage

// File: rtl/rv_ctrl_fsm_wait_timer.sv
// Memory-wait counter: counts stalled request cycles and flags expiry once
// TIMEOUT stalls have accumulated. TIMEOUT of 0 never expires.
module rv_ctrl_wait_timer #(
  parameter int TIMEOUT   = 200,
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LIMIT  = TIMEOUT_W'(TIMEOUT);
  localparam bit                   ENABLE = (TIMEOUT != 0);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  assign expired_o = ENABLE && (count_q == LIMIT);

  // Saturate at the limit so a held expiry cannot wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (wait_i && !expired_o)
      count_d = count_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/mem/wb stepping,
// datapath strobes, trap entry, halt and retired-instruction counting.
module rv_ctrl_fsm
  import rv_ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT   = 200,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  instr_type,
  input  logic [2:0]  funct3,
  input  logic        ebreak,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_load,
  output logic        mdr_load,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        alu_mode,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        halted,
  output logic        retire,
  output logic [31:0] instret
);

  ctrl_state_e state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q;
  logic        expired;
  logic        mem_wait;

  assign mem_wait   = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

  rv_ctrl_wait_timer #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .wait_i    (mem_wait),
    .clear_i   (state_d != state_q),
    .expired_o (expired)
  );

  // Everything stays at its default while rst is high, so mem_req drops at once.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    alu_a_sel    = ALU_A_RS1;
    alu_b_sel    = 1'b0;
    alu_mode     = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    pc_load      = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    trap         = 1'b0;
    halted       = 1'b0;
    retire       = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_d = DECODE;
          end else if (expired) begin
            state_d = TRAP;
            cause_d = CAUSE_BUS;
          end
        end
        DECODE: begin
          if (instr_type == INSTR_ERR) begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else if (opcode == OP_ECSR) begin
            if (funct3 != 3'd0) begin
              state_d = TRAP;
              cause_d = CAUSE_ILLEGAL;
            end else if (ebreak) begin
              state_d = HALT;
            end else begin
              state_d = TRAP;
              cause_d = CAUSE_ECALL;
            end
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          state_d = WB;
          case (opcode)
            OP_LUI: begin
              alu_a_sel = ALU_A_ZERO;
              alu_b_sel = 1'b1;
            end
            OP_AUIPC, OP_JAL: begin
              alu_a_sel = ALU_A_PC;
              alu_b_sel = 1'b1;
            end
            OP_BRANCH: begin
              alu_a_sel = ALU_A_PC;
              alu_b_sel = 1'b1;
              pc_load   = 1'b1;
              pc_sel    = br_taken ? PC_SEL_ALU : PC_SEL_PLUS4;
              retire    = 1'b1;
              state_d   = FETCH;
            end
            OP_JALR: alu_b_sel = 1'b1;
            OP_LD, OP_ST: begin
              alu_b_sel = 1'b1;
              state_d   = MEM;
            end
            OP_ALUI: begin
              alu_b_sel = 1'b1;
              alu_mode  = 1'b1;
            end
            OP_ALU:  alu_mode = 1'b1;
            default: ;
          endcase
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_ST);
          if (mem_ready) begin
            if (opcode == OP_ST) begin
              pc_load = 1'b1;
              retire  = 1'b1;
              state_d = FETCH;
            end else begin
              mdr_load = 1'b1;
              state_d  = WB;
            end
          end else if (expired) begin
            state_d = TRAP;
            cause_d = CAUSE_BUS;
          end
        end
        WB: begin
          rf_we   = (opcode != OP_FENCE);
          pc_load = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
          if (opcode == OP_LD) begin
            wb_sel = WB_SEL_MDR;
          end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
            wb_sel = WB_SEL_PC4;
            pc_sel = PC_SEL_ALU;
          end
        end
        TRAP: begin
          trap    = 1'b1;
          pc_load = 1'b1;
          pc_sel  = PC_SEL_TRAP;
          state_d = FETCH;
        end
        HALT:    halted = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      cause_q   <= CAUSE_ILLEGAL;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Directed bench for rv_ctrl_fsm: walks ALU, load, store, branch, trap,
// timeout, mid-transaction reset and halt sequences against hand-derived outputs.
module tb_rv_ctrl_fsm;
  import rv_ctrl_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  instr_type;
  logic [2:0]  funct3;
  logic        ebreak;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_load, mdr_load;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel, alu_mode, rf_we;
  logic [1:0]  wb_sel;
  logic        pc_load;
  logic [1:0]  pc_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        halted, retire;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  rv_ctrl_fsm #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .instr_type(instr_type),
    .funct3(funct3), .ebreak(ebreak), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .mdr_load(mdr_load), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_mode(alu_mode), .rf_we(rf_we), .wb_sel(wb_sel),
    .pc_load(pc_load), .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause),
    .halted(halted), .retire(retire), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, alu_a_sel,
                alu_b_sel, alu_mode, rf_we, wb_sel, pc_load, pc_sel, trap,
                halted, retire};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] ir, input logic [2:0] ty);
    opcode     = ir[6:0];
    funct3     = ir[14:12];
    ebreak     = ir[20];
    instr_type = ty;
  endtask

  // Expected control vector fields in port order, compared as one word.
  task automatic ctl(input string tag,
                     input logic rq, input logic we, input logic as,
                     input logic irl, input logic mdl, input logic [1:0] aa,
                     input logic ab, input logic am, input logic rfw,
                     input logic [1:0] wb, input logic pcl, input logic [1:0] pcs,
                     input logic tr, input logic hl, input logic rt);
    logic [17:0] e;
    #1;
    e = {rq, we, as, irl, mdl, aa, ab, am, rfw, wb, pcl, pcs, tr, hl, rt};
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  initial begin
    rst = 1'b1; br_taken = 1'b0; mem_ready = 1'b1;
    load_ir(32'h00500093, INSTR_I);
    ctl("reset_outputs", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0);
    chk("reset_instret", instret, 32'd0);
    chk("reset_cause", {30'd0, trap_cause}, 32'd0);
    tick(); rst = 1'b0;

    // ADDI x1,x0,5
    ctl("addi_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("addi_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("addi_exec", 0,0,0,0,0, 0,1,1,0, 0,0,0, 0,0,0); tick();
    ctl("addi_wb", 0,0,0,0,0, 0,0,0,1, 0,1,0, 0,0,1); tick();
    chk("addi_instret", instret, 32'd1);

    // LW with three stalled memory cycles
    load_ir(32'h0000A103, INSTR_I);
    ctl("lw_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("lw_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("lw_exec", 0,0,0,0,0, 0,1,0,0, 0,0,0, 0,0,0); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ctl("lw_mem_wait", 1,0,1,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    end
    mem_ready = 1'b1;
    ctl("lw_mem_done", 1,0,1,0,1, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("lw_wb", 0,0,0,0,0, 0,0,0,1, 1,1,0, 0,0,1); tick();
    chk("lw_instret", instret, 32'd2);

    // SW: ready arrives on the very cycle the wait counter expires
    load_ir(32'h0020A023, INSTR_S);
    ctl("sw_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("sw_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("sw_exec", 0,0,0,0,0, 0,1,0,0, 0,0,0, 0,0,0); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ctl("sw_mem_wait", 1,1,1,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    end
    mem_ready = 1'b1;
    ctl("sw_ready_at_expiry", 1,1,1,0,0, 0,0,0,0, 0,1,0, 0,0,1); tick();
    chk("sw_instret", instret, 32'd3);

    // BEQ taken, then not taken
    load_ir(32'h00208463, INSTR_B);
    br_taken = 1'b1;
    ctl("beq_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("beq_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("beq_taken", 0,0,0,0,0, 1,1,0,0, 0,1,1, 0,0,1); tick();
    br_taken = 1'b0;
    ctl("beq2_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("beq2_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("beq_not_taken", 0,0,0,0,0, 1,1,0,0, 0,1,0, 0,0,1); tick();
    chk("beq_instret", instret, 32'd5);

    // Illegal instruction, then ECALL
    load_ir(32'hFFFFFFFF, INSTR_ERR);
    ctl("ill_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("ill_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("ill_trap", 0,0,0,0,0, 0,0,0,0, 0,1,2, 1,0,0);
    chk("ill_cause", {30'd0, trap_cause}, 32'd0); tick();
    load_ir(32'h00000073, INSTR_I);
    ctl("ecall_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("ecall_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("ecall_trap", 0,0,0,0,0, 0,0,0,0, 0,1,2, 1,0,0);
    chk("ecall_cause", {30'd0, trap_cause}, 32'd1); tick();
    chk("trap_instret", instret, 32'd5);

    // LW with memory stuck: bus timeout after TIMEOUT+1 stalled cycles
    load_ir(32'h0000A103, INSTR_I);
    ctl("lwto_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("lwto_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("lwto_exec", 0,0,0,0,0, 0,1,0,0, 0,0,0, 0,0,0); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ctl("lwto_mem_wait", 1,0,1,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    end
    ctl("lwto_trap", 0,0,0,0,0, 0,0,0,0, 0,1,2, 1,0,0);
    chk("lwto_cause", {30'd0, trap_cause}, 32'd2); tick();

    // Reset in the middle of a stalled MEM access
    mem_ready = 1'b1;
    ctl("rstm_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("rstm_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("rstm_exec", 0,0,0,0,0, 0,1,0,0, 0,0,0, 0,0,0); tick();
    mem_ready = 1'b0;
    tick(); tick();
    ctl("rstm_pre_reset", 1,0,1,0,0, 0,0,0,0, 0,0,0, 0,0,0);
    rst = 1'b1;
    ctl("rstm_during_reset", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0);
    chk("rstm_instret", instret, 32'd0);
    chk("rstm_cause", {30'd0, trap_cause}, 32'd0);
    tick(); rst = 1'b0;

    // Stalled fetch after reset times out with a freshly cleared counter
    for (int i = 0; i < 5; i++) begin
      ctl("fetchto_wait", 1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    end
    ctl("fetchto_trap", 0,0,0,0,0, 0,0,0,0, 0,1,2, 1,0,0);
    chk("fetchto_cause", {30'd0, trap_cause}, 32'd2); tick();

    // EBREAK halts until reset
    mem_ready = 1'b1;
    load_ir(32'h00100073, INSTR_I);
    ctl("ebreak_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    ctl("ebreak_decode", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0); tick();
    for (int i = 0; i < 100; i++) begin
      ctl("halt_hold", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,1,0); tick();
    end
    rst = 1'b1;
    ctl("halt_reset", 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0);
    tick(); rst = 1'b0;
    ctl("post_halt_fetch", 1,0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0);
    chk("post_halt_instret", instret, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
